// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
//   jump_t     - encoding of the 2-bit jump control field
//   BR_*       - 3-bit conditional-branch codes
package pc_pkg;

  typedef enum logic [1:0] {
    J_NONE = 2'b00,
    J_J    = 2'b01,
    J_JAL  = 2'b10,
    J_RSVD = 2'b11   // behaves as a plain j
  } jump_t;

  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLEZ = 3'b110;
  localparam logic [2:0] BR_BGTZ = 3'b111;
  localparam logic [2:0] BR_BGEZ = 3'b001;
  localparam logic [2:0] BR_BLTZ = 3'b011;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: circular return-address stack with a saturating entry count.
//   clk, rst   - clock, synchronous active-high reset (clears count/pointer)
//   push       - write push_data on top (overwrites the oldest entry when full)
//   pop        - discard top entry; ignored when empty
//   push_data  - address to push
//   top        - current top entry (meaningless while empty)
//   empty      - no valid entry held
// push and pop are never asserted together by the parent.
module return_stack #(
  parameter int N         = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] push_data,
  output logic [N-1:0] top,
  output logic         empty
);

  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W     = $clog2(RAS_DEPTH + 1);
  localparam logic [RAS_PTR_W-1:0] PTR_ONE = RAS_PTR_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [N-1:0]         mem [RAS_DEPTH];
  // ptr is the next free slot; the top entry sits one below it.
  logic [RAS_PTR_W-1:0] ptr;
  logic [CNT_W-1:0]     count;

  assign top   = mem[ptr - PTR_ONE];
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      // Pointer wraps freely, so a push on a full stack lands on the oldest slot.
      mem[ptr] <= push_data;
      ptr      <= ptr + PTR_ONE;
      if (count != CNT_MAX) count <= count + CNT_ONE;
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with next-PC selection and a
// return-address stack used to profile jr prediction.
//   clk, rst                      - clock, synchronous active-high reset
//   stall, trap                   - hold PC / redirect to TRAP_VEC
//   jump, jr, branch, zero        - control-flow decode and ALU zero flag
//   address                       - 26-bit j/jal target field
//   sign_extend_immediate         - branch word offset
//   rs_data                       - rs register value (jr target, branch compares)
//   pc, next_pc, link_addr        - current PC, PC for next edge, pc+4
//   ras_empty                     - return stack holds nothing
//   ret_pred_ok / ret_pred_miss   - one-cycle pulses after each executed jr
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int             N         = 32,
  parameter logic [N-1:0]   RESET_PC  = N'(32'h0000_0000),
  parameter logic [N-1:0]   TRAP_VEC  = N'(32'h8000_0180),
  parameter int             RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         trap,
  input  logic [1:0]   jump,
  input  logic         jr,
  input  logic [2:0]   branch,
  input  logic         zero,
  input  logic [25:0]  address,
  input  logic [N-1:0] sign_extend_immediate,
  input  logic [N-1:0] rs_data,
  output logic [N-1:0] pc,
  output logic [N-1:0] next_pc,
  output logic [N-1:0] link_addr,
  output logic         ras_empty,
  output logic         ret_pred_ok,
  output logic         ret_pred_miss
);

  jump_t        jump_kind;
  logic [N-1:0] pc4;
  logic [N-1:0] br_target;
  logic [N-1:0] j_target;
  logic         br_taken;
  logic         rs_neg;
  logic         rs_zero;
  logic         ras_update;
  logic         ras_push;
  logic         ras_pop;
  logic [N-1:0] ras_top;

  assign jump_kind = jump_t'(jump);
  assign pc4       = pc + N'(4);
  assign br_target = pc4 + (sign_extend_immediate << 2);
  assign j_target  = {pc4[N-1:28], address, 2'b00};
  assign link_addr = pc4;

  assign rs_neg  = rs_data[N-1];
  assign rs_zero = (rs_data == '0);

  always_comb begin
    br_taken = 1'b0;
    case (branch)
      BR_BEQ:  br_taken = zero;
      BR_BNE:  br_taken = !zero;
      BR_BLEZ: br_taken = rs_neg || rs_zero;
      BR_BGTZ: br_taken = !rs_neg && !rs_zero;
      BR_BGEZ: br_taken = !rs_neg;
      BR_BLTZ: br_taken = rs_neg;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc4;
    if (trap)                   next_pc = TRAP_VEC;
    else if (stall)             next_pc = pc;
    else if (jump_kind != J_NONE) next_pc = j_target;
    else if (jr)                next_pc = rs_data;
    else if (br_taken)          next_pc = br_target;
  end

  // The stack only moves on instructions that actually retire this cycle;
  // a jump decoded alongside jr wins, so that jr never pops.
  assign ras_update = !trap && !stall;
  assign ras_push   = ras_update && (jump_kind == J_JAL);
  assign ras_pop    = ras_update && (jump_kind == J_NONE) && jr;

  return_stack #(
    .N         (N),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_addr),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      ret_pred_ok   <= 1'b0;
      ret_pred_miss <= 1'b0;
    end else begin
      pc            <= next_pc;
      ret_pred_ok   <= ras_pop && !ras_empty && (ras_top == rs_data);
      ret_pred_miss <= ras_pop && (ras_empty || (ras_top != rs_data));
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        trap;
  logic [1:0]  jump;
  logic        jr;
  logic [2:0]  branch;
  logic        zero;
  logic [25:0] address;
  logic [31:0] sign_extend_immediate;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] link_addr;
  logic        ras_empty;
  logic        ret_pred_ok;
  logic        ret_pred_miss;

  int checks = 0;
  int errors = 0;

  // Expected link addresses of the five back-to-back jal pushes.
  logic [31:0] exp_q[$];

  pc_sequencer dut (
    .clk                   (clk),
    .rst                   (rst),
    .stall                 (stall),
    .trap                  (trap),
    .jump                  (jump),
    .jr                    (jr),
    .branch                (branch),
    .zero                  (zero),
    .address               (address),
    .sign_extend_immediate (sign_extend_immediate),
    .rs_data               (rs_data),
    .pc                    (pc),
    .next_pc               (next_pc),
    .link_addr             (link_addr),
    .ras_empty             (ras_empty),
    .ret_pred_ok           (ret_pred_ok),
    .ret_pred_miss         (ret_pred_miss)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_ctrl();
    stall = 0; trap = 0; jump = 2'b00; jr = 0; branch = 3'b000; zero = 0;
    address = '0; sign_extend_immediate = '0; rs_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic e_empty, input logic e_ok,
                             input logic e_miss);
    check({tag, "_empty"}, 32'(ras_empty), 32'(e_empty));
    check({tag, "_ok"}, 32'(ret_pred_ok), 32'(e_ok));
    check({tag, "_miss"}, 32'(ret_pred_miss), 32'(e_miss));
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [31:0] link;
    clear_ctrl();
    rst = 1;
    step();
    step();
    check("reset_pc", pc, 32'h0);
    check_flags("reset", 1, 0, 0);
    rst = 0;
    step();
    check("seq_pc4", pc, 32'h4);
    step();
    check("seq_pc8", pc, 32'h8);
    check_flags("seq", 1, 0, 0);

    // j to 0x100 (address 0x40)
    jump = 2'b01; address = 26'h40;
    step();
    clear_ctrl();
    check("j_pc", pc, 32'h100);
    check("j_no_push", 32'(ras_empty), 32'd1);

    // Branch targets at pc=0x100, offset -2 words
    sign_extend_immediate = 32'hFFFF_FFFE;
    branch = 3'b100; zero = 1; #1;
    check("beq_taken", next_pc, 32'h0FC);
    branch = 3'b101; #1;
    check("bne_not", next_pc, 32'h104);
    branch = 3'b011; zero = 0; rs_data = 32'hFFFF_FFFF; #1;
    check("bltz_taken", next_pc, 32'h0FC);
    rs_data = 32'h0; #1;
    check("bltz_zero_not", next_pc, 32'h104);
    branch = 3'b110; #1;
    check("blez_zero", next_pc, 32'h0FC);
    branch = 3'b111; #1;
    check("bgtz_zero_not", next_pc, 32'h104);
    branch = 3'b001; #1;
    check("bgez_zero", next_pc, 32'h0FC);
    branch = 3'b010; zero = 1; #1;
    check("br_other_not", next_pc, 32'h104);
    branch = 3'b011;
    step();
    check("br_pc", pc, 32'h104);
    clear_ctrl();

    // Move to 0x200, jal to 0x100, then jr back with a correct prediction
    jump = 2'b11; address = 26'h80;
    step();
    check("jrsvd_pc", pc, 32'h200);
    jump = 2'b10; address = 26'h40; #1;
    check("link_addr", link_addr, 32'h204);
    step();
    clear_ctrl();
    check("jal_pc", pc, 32'h100);
    check_flags("jal", 0, 0, 0);
    jr = 1; rs_data = 32'h204;
    step();
    clear_ctrl();
    check("jr_pc", pc, 32'h204);
    check_flags("jr_hit", 1, 1, 0);
    step();
    check("idle_pc", pc, 32'h208);
    check_flags("pulse_end", 1, 0, 0);

    // Five jal pushes into a 4-deep stack; the first link is overwritten
    for (int i = 0; i < 5; i++) begin
      jump = 2'b10; address = 26'h100 + 26'(i * 'h10);
      link = pc + 32'd4;
      exp_q.push_back(link);
      if (exp_q.size() > 4) void'(exp_q.pop_front());
      step();
      check("push_pc", pc, 32'h400 + 32'(i * 'h40));
    end
    clear_ctrl();
    check("five_links", exp_q[0], 32'h404);
    for (int i = 0; i < 4; i++) begin
      jr = 1; rs_data = exp_q.pop_back();
      step();
      check("pop_pc", pc, rs_data);
      check_flags("pop_lifo", (i == 3), 1, 0);
    end
    jr = 1; rs_data = 32'h20C;
    step();
    clear_ctrl();
    check("pop5_pc", pc, 32'h20C);
    check_flags("pop_empty", 1, 0, 1);

    // Stall with jal and a taken branch: nothing moves, then runs once
    stall = 1; jump = 2'b10; address = 26'h90; branch = 3'b100; zero = 1;
    #1;
    check("stall_next", next_pc, 32'h20C);
    step();
    check("stall_pc", pc, 32'h20C);
    check_flags("stall", 1, 0, 0);
    stall = 0;
    step();
    clear_ctrl();
    check("unstall_pc", pc, 32'h240);
    check_flags("unstall", 0, 0, 0);
    step();
    check("once_pc", pc, 32'h244);

    // j with jr: the jump wins and the stack is not popped
    jump = 2'b01; address = 26'h92; jr = 1; rs_data = 32'h0;
    step();
    clear_ctrl();
    check("jjr_pc", pc, 32'h248);
    check_flags("jjr", 0, 0, 0);

    // Stalled jr: no pop, no pulse
    stall = 1; jr = 1; rs_data = 32'h210;
    step();
    check("stall_jr_pc", pc, 32'h248);
    check_flags("stall_jr", 0, 0, 0);

    // Trap beats stall and jr
    trap = 1;
    step();
    clear_ctrl();
    check("trap_pc", pc, 32'h8000_0180);
    check_flags("trap", 0, 0, 0);

    // Stack survived the trap: the saved link still predicts correctly
    jr = 1; rs_data = 32'h210;
    step();
    clear_ctrl();
    check("post_trap_pc", pc, 32'h210);
    check_flags("post_trap", 1, 1, 0);

    // Mispredicted jr with a non-empty stack
    jump = 2'b10; address = 26'h10;
    step();
    address = 26'h20;
    step();
    clear_ctrl();
    check("jal2_pc", pc, 32'h80);
    jr = 1; rs_data = 32'h0;
    step();
    clear_ctrl();
    check("miss_pc", pc, 32'h0);
    check_flags("miss", 0, 0, 1);

    // Reset with a live entry (and a jal on the inputs) clears the stack
    rst = 1; jump = 2'b10; address = 26'h55;
    step();
    clear_ctrl();
    rst = 0;
    check("rst_mid_pc", pc, 32'h0);
    check_flags("rst_mid", 1, 0, 0);
    jr = 1; rs_data = 32'h214;
    step();
    clear_ctrl();
    check("rst_jr_pc", pc, 32'h214);
    check_flags("rst_jr", 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the single-issue MIPS core. Generalises the combinational next-PC selector.
- Holds the architectural PC and computes the next PC for:
  - jump, jump-and-link, jr and the six conditional branches;
  - stall and trap redirect.
- Contains a parametrised return-address stack (RAS). On each jr, the RAS prediction is compared with rs_data and the result is reported for profiling and future prediction use.

Parameters:
- N, 32, datapath/PC width (>= 32).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h8000_0180, PC value loaded on trap.
- RAS_DEPTH, 4, return-stack entries (power of two, >= 2).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS this cycle.
- trap  in  1  redirect to TRAP_VEC.
- jump  in  2  00 none, 01 j, 10 jal, 11 reserved (treated as j).
- jr  in  1  jump-register.
- branch  in  3  branch code (see Behaviour).
- zero  in  1  ALU zero flag.
- address  in  26  jump target field.
- sign_extend_immediate  in  N  branch offset (words).
- rs_data  in  N  rs register value.
- pc  out  N  current PC (registered).
- next_pc  out  N  combinational PC to be loaded at next edge.
- link_addr  out  N  pc+4 (jal link value).
- ras_empty  out  1  RAS holds no valid entry.
- ret_pred_ok  out  1  registered pulse: last jr matched RAS top.
- ret_pred_miss  out  1  registered pulse: last jr mismatched, or RAS was empty.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC;
  - RAS count=0, pointer=0, ras_empty=1;
  - ret_pred_ok=0 and ret_pred_miss=0.
  - rst overrides every other input.
- pc4 = pc + 4, modulo 2^N. Branch target = pc4 + (sign_extend_immediate << 2), truncated to N bits; this applies to all branches, including beq.
- next_pc priority, highest first:
  1. trap -> TRAP_VEC.
  2. stall -> pc.
  3. jump!=00 -> {pc4[31:28], address, 2'b00}, with upper bits of pc4 when N>32.
  4. jr -> rs_data.
  5. branch taken -> target.
  6. Otherwise pc4.
- Branch codes, using signed compare on rs_data:
  - 100 beq: zero=1.
  - 101 bne: zero=0.
  - 110 blez: rs<=0.
  - 111 bgtz: rs>0.
  - 001 bgez: rs>=0.
  - 011 bltz: rs<0.
  - All other codes: not taken.
- pc <= next_pc every edge. Latency is 1 cycle; trap also takes effect at the next edge.
- The RAS updates only when rst=0, trap=0 and stall=0.
  - jal (jump=10): push link_addr.
    - Full stack: the oldest entry is overwritten (circular pointer wraps) and count saturates at RAS_DEPTH.
  - jr (with jump=00): pop.
    - Non-empty: compare top with rs_data. Next cycle ret_pred_ok=1 on match, else ret_pred_miss=1. Pointer decrements and count decrements.
    - Empty: ret_pred_miss=1 next cycle; pointer and count are unchanged.
  - jump!=00 together with jr: the jump wins and no pop occurs.
  - Push and pop never occur in the same cycle.
- ret_pred_ok and ret_pred_miss are single-cycle pulses; they are 0 in every other cycle, including the cycle after a stalled jr.
- A trap does not modify the RAS.
- Reset asserted mid-sequence clears the RAS contents-valid state (count=0) regardless of prior pushes.
- The prediction outputs are informational only. next_pc always uses rs_data for jr.

Decomposition:
- Package pc_pkg:
  - typedef enum jump_t (J_NONE, J_J, J_JAL, J_RSVD);
  - branch code localparams (BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BGEZ, BR_BLTZ);
  - localparam RAS_PTR_W = $clog2(RAS_DEPTH) is computed in the module.
- Sub-module return_stack:
  - Parameters: N, RAS_DEPTH.
  - Ports: clk, rst, push, pop, push_data, top, empty.
  - Implements the circular, saturating-count stack.
- pc_sequencer holds the PC register, the next-PC mux and the prediction pulses.

Test Plan:
- rst=1 for 2 cycles, then release with no control inputs -> pc sequence 0x0, 0x4, 0x8; ras_empty=1.
- pc=0x100, branch=100, zero=1, imm=0xFFFF_FFFE -> next pc 0x0FC. Repeat with branch=011 and rs=0xFFFF_FFFF -> bltz taken, same target. Repeat with rs=0 -> 0x104.
- pc=0x200, jump=10, address=0x40 -> pc=0x100, RAS top=0x204. Then jr with rs_data=0x204 -> pc=0x204 and ret_pred_ok pulses for exactly 1 cycle.
- Sequence:
  - 5 jal pushes with RAS_DEPTH=4 -> 4 pops return the last four link addresses in LIFO order;
  - 5th pop -> ret_pred_miss=1 with ras_empty=1.
- stall=1 together with jal and branch-taken -> pc unchanged and RAS unchanged; release -> the action executes once.
- trap=1 together with stall=1 and jr -> pc=0x8000_0180, RAS unchanged, no prediction pulse. Then rst during a non-empty RAS -> ras_empty=1 and pc=RESET_PC next cycle.
